// File: rtl/tekbot_sequencer.sv
// tekbot_sequencer: bump-and-turn motor sequencer (FWD -> REV -> TURN -> FWD) paced by a tick prescaler.
//   clk_i            system clock, rising edge
//   reset_n          asynchronous active-low reset
//   bump_l_n/r_n     active-low bumpers, asynchronous to clk_i
//   motor_*_en/dir   registered motor enables and directions (dir 1 = forward)
//   state_o          registered state: FWD=0, REV=1, TURN_L=2, TURN_R=3
//   tick_o           one-clock pulse while the prescaler sits at TICK_MAX
module tekbot_sequencer #(
  parameter int TICK_MAX   = 207999,
  parameter int REV_TICKS  = 10,
  parameter int TURN_TICKS = 5
) (
  input  logic       clk_i,
  input  logic       reset_n,
  input  logic       bump_l_n,
  input  logic       bump_r_n,
  output logic       motor_l_en,
  output logic       motor_r_en,
  output logic       motor_l_dir,
  output logic       motor_r_dir,
  output logic [1:0] state_o,
  output logic       tick_o
);
  typedef enum logic [1:0] {FWD = 2'd0, REV = 2'd1, TURN_L = 2'd2, TURN_R = 2'd3} state_t;
  state_t      state_q, state_d, turn_q, turn_d;
  logic [1:0]  sync_l_q, sync_r_q;
  logic [20:0] presc_q, presc_d;
  logic [7:0]  phase_q, phase_d;
  logic [3:0]  out_q, out_d;
  logic [1:0]  state_o_q;
  logic        tick_q, tick_d, tick, bump, last, moved;
  always_comb begin
    tick    = presc_q == 21'(TICK_MAX);
    bump    = ~sync_l_q[1] | ~sync_r_q[1];
    // exit on the tick that would bring the phase count up to its terminal value
    last    = state_q == REV ? phase_q == 8'(REV_TICKS - 1) : phase_q == 8'(TURN_TICKS - 1);
    state_d = state_q == FWD ? (bump ? REV : FWD) : (tick && last) ? (state_q == REV ? turn_q : FWD) : state_q;
    // left bumper (alone or with right) turns right; right alone turns left
    turn_d  = (state_q == FWD && bump) ? (~sync_l_q[1] ? TURN_R : TURN_L) : turn_q;
    moved   = state_d != state_q;
    presc_d = (moved || tick) ? '0 : presc_q + 1'b1;
    phase_d = (moved || state_q == FWD) ? '0 : tick ? phase_q + 1'b1 : phase_q;
    tick_d  = presc_d == 21'(TICK_MAX);
    // {l_en, r_en, l_dir, r_dir}
    out_d   = state_q == FWD ? 4'b1111 : state_q == REV ? 4'b1100 : state_q == TURN_L ? 4'b1101 : 4'b1110;
  end
  always_ff @(posedge clk_i or negedge reset_n) begin
    if (!reset_n) begin
      sync_l_q  <= 2'b11;
      sync_r_q  <= 2'b11;
      state_q   <= FWD;
      turn_q    <= TURN_R;
      presc_q   <= '0;
      phase_q   <= '0;
      out_q     <= 4'b0011;
      state_o_q <= 2'd0;
      tick_q    <= 1'b0;
    end else begin
      sync_l_q  <= {sync_l_q[0], bump_l_n};
      sync_r_q  <= {sync_r_q[0], bump_r_n};
      state_q   <= state_d;
      turn_q    <= turn_d;
      presc_q   <= presc_d;
      phase_q   <= phase_d;
      out_q     <= out_d;
      state_o_q <= state_q;
      tick_q    <= tick_d;
    end
  end
  assign {motor_l_en, motor_r_en, motor_l_dir, motor_r_dir} = out_q;
  assign state_o = state_o_q;
  assign tick_o  = tick_q;
endmodule

// File: tb/tb_tekbot_sequencer.sv
// tb_tekbot_sequencer: directed bench for tekbot_sequencer with TICK_MAX=3, REV_TICKS=2, TURN_TICKS=1.
module tb_tekbot_sequencer;
  logic clk_i = 1'b0, reset_n = 1'b0, bump_l_n = 1'b1, bump_r_n = 1'b1;
  logic motor_l_en, motor_r_en, motor_l_dir, motor_r_dir, tick_o;
  logic [1:0] state_o;
  int checks = 0, failures = 0;
  tekbot_sequencer #(.TICK_MAX(3), .REV_TICKS(2), .TURN_TICKS(1)) dut (
    .clk_i(clk_i), .reset_n(reset_n), .bump_l_n(bump_l_n), .bump_r_n(bump_r_n),
    .motor_l_en(motor_l_en), .motor_r_en(motor_r_en), .motor_l_dir(motor_l_dir),
    .motor_r_dir(motor_r_dir), .state_o(state_o), .tick_o(tick_o)
  );
  always #5 clk_i = ~clk_i;
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge clk_i);
    #1;
  endtask
  function automatic logic [3:0] motors();
    return {motor_l_en, motor_r_en, motor_l_dir, motor_r_dir};
  endfunction
  task automatic run_len(input logic [1:0] st, output int len);
    len = 1;
    while (len < 50) begin
      step();
      if (state_o != st) break;
      len++;
    end
  endtask
  task automatic wait_state(input logic [1:0] st, output int n);
    n = 0;
    while (state_o != st && n < 50) begin
      step();
      n++;
    end
  endtask
  // press (l, r) for one clock, optionally pulse the left bumper at REV clock pulse_at
  task automatic seq(input string tag, input logic l, input logic r, input logic [1:0] exp_turn, input int pulse_at);
    int n, len;
    bump_l_n = ~l;
    bump_r_n = ~r;
    step();
    bump_l_n = 1'b1;
    bump_r_n = 1'b1;
    wait_state(2'd1, n);
    check({tag, "_latency"}, n, 3);
    check({tag, "_rev_motors"}, motors(), 4'b1100);
    len = 1;
    while (len < 50) begin
      if (len == pulse_at) bump_l_n = 1'b0;
      step();
      bump_l_n = 1'b1;
      if (state_o != 2'd1) break;
      len++;
    end
    check({tag, "_rev_len"}, len, 8);
    check({tag, "_turn_state"}, state_o, exp_turn);
    check({tag, "_turn_motors"}, motors(), exp_turn == 2'd2 ? 4'b1101 : 4'b1110);
    run_len(exp_turn, len);
    check({tag, "_turn_len"}, len, 4);
    check({tag, "_fwd_state"}, state_o, 2'd0);
    check({tag, "_fwd_motors"}, motors(), 4'b1111);
    repeat (3) step();
  endtask
  initial begin
    int n, len, cnt;
    #12;
    check("rst_motors", motors(), 4'b0011);
    check("rst_state", state_o, 2'd0);
    check("rst_tick", tick_o, 1'b0);
    @(negedge clk_i);
    reset_n = 1'b1;
    step();
    check("rel_motors", motors(), 4'b1111);
    check("rel_state", state_o, 2'd0);
    n = 0;
    while (!tick_o && n < 10) begin step(); n++; end
    check("tick_first", tick_o, 1'b1);
    for (int p = 0; p < 3; p++) begin
      n = 0;
      do begin step(); n++; end while (!tick_o && n < 10);
      check("tick_period", n, 4);
    end
    cnt = 0;
    for (int i = 0; i < 12; i++) begin step(); cnt += tick_o; end
    check("tick_count12", cnt, 3);
    seq("left", 1'b1, 1'b0, 2'd3, 0);
    seq("right", 1'b0, 1'b1, 2'd2, 0);
    seq("both", 1'b1, 1'b1, 2'd3, 0);
    seq("pulse", 1'b0, 1'b1, 2'd2, 3);
    bump_r_n = 1'b0;
    wait_state(2'd1, n);
    check("hold_enter", state_o, 2'd1);
    run_len(2'd1, len);
    check("hold_rev1", len, 8);
    run_len(2'd2, len);
    check("hold_turn", len, 4);
    run_len(2'd0, len);
    check("hold_fwd", len, 1);
    run_len(2'd1, len);
    check("hold_rev2", len, 8);
    bump_r_n = 1'b1;
    wait_state(2'd0, n);
    check("hold_exit", state_o, 2'd0);
    repeat (5) step();
    bump_l_n = 1'b0;
    step();
    bump_l_n = 1'b1;
    wait_state(2'd1, n);
    repeat (4) step();
    check("mid_rev", state_o, 2'd1);
    reset_n = 1'b0;
    #1;
    check("arst_motors", motors(), 4'b0011);
    check("arst_state", state_o, 2'd0);
    check("arst_tick", tick_o, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_n = 1'b1;
    step();
    check("arel_motors", motors(), 4'b1111);
    cnt = 0;
    for (int i = 0; i < 20; i++) begin step(); cnt += (state_o != 2'd0); end
    check("arel_stay_fwd", cnt, 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
